// File: rtl/spi_debug_master.sv
// spi_debug_master: SPI mode-0 initiator for 32-bit debug write frames {addr, data}, MSB first.
// Ports:
//   clk, reset            - system clock, asynchronous active-high reset
//   req_valid/req_ready   - request handshake; req_ready is high only in IDLE
//   req_addr, req_data    - 16-bit address and data, latched on the handshake edge
//   done                  - one-cycle pulse when a frame completes
//   rx_data               - 32-bit word shifted in from spi_miso during the last frame
//   busy                  - high whenever the block is not idle
//   spi_clk, spi_cs, spi_mosi, spi_miso - SPI pins (mode 0, active-low select)
module spi_debug_master #(
    parameter int CLKDIV = 2,
    parameter int GAP    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_data,
    output logic        done,
    output logic [31:0] rx_data,
    output logic        busy,
    output logic        spi_clk,
    output logic        spi_cs,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);
    // The IDLE cycle before the next handshake also keeps spi_cs high, so the
    // GAP state itself lasts one cycle less than the required high time.
    localparam logic [7:0] GAP_LAST = 8'((GAP > 1) ? GAP - 2 : 0);

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [4:0]  bit_cnt, bit_n;
    logic [31:0] tx_shift, tx_n, rx_shift, rx_n, rxd_n;
    logic        done_n, phase_end;

    assign req_ready = state == S_IDLE;
    assign busy      = state != S_IDLE;
    assign phase_end = cnt == DIV_LAST;

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 8'd1;
        bit_n   = bit_cnt;
        tx_n    = tx_shift;
        rx_n    = rx_shift;
        rxd_n   = rx_data;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = 8'd0;
                if (req_valid) begin
                    state_n = S_SETUP;
                    tx_n    = {req_addr, req_data};
                    bit_n   = 5'd0;
                end
            end
            S_SETUP, S_LOW: begin
                if (phase_end) begin
                    state_n = S_HIGH;
                    cnt_n   = 8'd0;
                end
            end
            S_HIGH: begin
                if (phase_end) begin
                    cnt_n = 8'd0;
                    rx_n  = {rx_shift[30:0], spi_miso};
                    if (bit_cnt == 5'd31) begin
                        state_n = S_HOLD;
                    end else begin
                        state_n = S_LOW;
                        tx_n    = {tx_shift[30:0], 1'b0};
                        bit_n   = bit_cnt + 5'd1;
                    end
                end
            end
            S_HOLD: begin
                if (phase_end) begin
                    state_n = S_GAP;
                    cnt_n   = 8'd0;
                    done_n  = 1'b1;
                    rxd_n   = rx_shift;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_n = S_IDLE;
                    cnt_n   = 8'd0;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Pin values are registered from the next state so every pin comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            bit_cnt  <= 5'd0;
            tx_shift <= 32'd0;
            rx_shift <= 32'd0;
            rx_data  <= 32'd0;
            done     <= 1'b0;
            spi_cs   <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_n;
            tx_shift <= tx_n;
            rx_shift <= rx_n;
            rx_data  <= rxd_n;
            done     <= done_n;
            spi_cs   <= state_n == S_IDLE || state_n == S_GAP;
            spi_clk  <= state_n == S_HIGH;
            spi_mosi <= (state_n == S_SETUP || state_n == S_HIGH || state_n == S_LOW) && tx_n[31];
        end
    end
endmodule

// File: tb/tb_spi_debug_master.sv
// tb_spi_debug_master: directed checks of spi_debug_master at CLKDIV=2 and CLKDIV=1.
module tb_spi_debug_master;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        loop = 1'b0;
    logic        miso_v = 1'b1;
    logic        miso_a;
    logic [1:0]  rv = 2'b00;
    logic [15:0] ra [2];
    logic [15:0] rd [2];
    logic [1:0]  rdy, dn, bsy, sclk, cs, mosi;
    logic [31:0] rxd [2];
    int total = 0;
    int bad = 0;

    int          rises [2] = '{0, 0};
    int          lowc  [2] = '{0, 0};
    int          dcnt  [2] = '{0, 0};
    int          cviol [2] = '{0, 0};
    int          rviol [2] = '{0, 0};
    int          hirun [2] = '{0, 0};
    int          lasthi[2] = '{0, 0};
    logic [31:0] cap   [2] = '{32'd0, 32'd0};
    logic [1:0]  psclk = 2'b00;
    int          r0, l0, d0;

    always #5 clk = ~clk;

    assign miso_a = loop ? mosi[0] : miso_v;

    spi_debug_master #(.CLKDIV(2), .GAP(4)) dut_a (
        .clk(clk), .reset(reset), .req_valid(rv[0]), .req_ready(rdy[0]),
        .req_addr(ra[0]), .req_data(rd[0]), .done(dn[0]), .rx_data(rxd[0]),
        .busy(bsy[0]), .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso_a)
    );

    spi_debug_master #(.CLKDIV(1), .GAP(4)) dut_b (
        .clk(clk), .reset(reset), .req_valid(rv[1]), .req_ready(rdy[1]),
        .req_addr(ra[1]), .req_data(rd[1]), .done(dn[1]), .rx_data(rxd[1]),
        .busy(bsy[1]), .spi_clk(sclk[1]), .spi_cs(cs[1]), .spi_mosi(mosi[1]),
        .spi_miso(1'b0)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (sclk[i] && !psclk[i]) begin
                rises[i]++;
                cap[i] = {cap[i][30:0], mosi[i]};
            end
            psclk[i] = sclk[i];
            if (!cs[i]) lowc[i]++;
            if (dn[i]) dcnt[i]++;
            if (sclk[i] && cs[i]) cviol[i]++;
            if (rdy[i] && !cs[i]) rviol[i]++;
            if (cs[i]) hirun[i]++;
            else begin
                if (hirun[i] != 0) lasthi[i] = hirun[i];
                hirun[i] = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap(input int i);
        r0 = rises[i];
        l0 = lowc[i];
        d0 = dcnt[i];
    endtask

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        ra[i] = a;
        rd[i] = d;
        rv[i] = 1'b1;
        while (!rdy[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
        ra[i] = 16'hA5A5;
        rd[i] = 16'h5A5A;
    endtask

    task automatic wait_done(input int i, input string tag);
        int n = 0;
        while (!dn[i] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(dn[i]), 32'd1);
    endtask

    initial begin
        ra[0] = 16'h0; rd[0] = 16'h0; ra[1] = 16'h0; rd[1] = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_cs", 32'(cs[0]), 32'd1);
        check("rst_clk", 32'(sclk[0]), 32'd0);
        check("rst_mosi", 32'(mosi[0]), 32'd0);
        check("rst_done", 32'(dn[0]), 32'd0);
        check("rst_rx", rxd[0], 32'h0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", 32'(rdy[0]), 32'd1);
        check("idle_busy", 32'(bsy[0]), 32'd0);

        // miso tied high
        snap(0);
        send(0, 16'h8005, 16'h0041);
        wait_done(0, "s1_done");
        check("s1_rx", rxd[0], 32'hFFFFFFFF);
        @(negedge clk);
        check("s1_done_pulse", 32'(dn[0]), 32'd0);
        check("s1_mosi_bits", cap[0], 32'h80050041);
        check("s1_cs_low", 32'(lowc[0] - l0), 32'd130);
        check("s1_rises", 32'(rises[0] - r0), 32'd32);
        check("s1_done_cnt", 32'(dcnt[0] - d0), 32'd1);

        // loopback
        loop = 1'b1;
        repeat (10) @(negedge clk);
        send(0, 16'hF000, 16'h0001);
        wait_done(0, "s2_done");
        check("s2_rx", rxd[0], 32'hF0000001);

        // back-to-back with req_valid held high
        repeat (10) @(negedge clk);
        snap(0);
        @(negedge clk);
        ra[0] = 16'h1111; rd[0] = 16'h2222; rv[0] = 1'b1;
        @(posedge clk);
        #1;
        ra[0] = 16'h3333; rd[0] = 16'h4444;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rdy[0] && n < 2000);
        end
        check("s3_ready_again", 32'(rdy[0]), 32'd1);
        check("s3_first_done", 32'(dcnt[0] - d0), 32'd1);
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        wait_done(0, "s3_done2");
        check("s3_rx", rxd[0], 32'h33334444);
        @(negedge clk);
        check("s3_done_cnt", 32'(dcnt[0] - d0), 32'd2);
        check("s3_gap", 32'(lasthi[0]), 32'd4);
        check("s3_cs_low", 32'(lowc[0] - l0), 32'd260);
        check("s3_mosi_bits", cap[0], 32'h33334444);

        // reset during bit 10
        repeat (10) @(negedge clk);
        snap(0);
        send(0, 16'hABCD, 16'h0123);
        begin
            int n = 0;
            while (rises[0] - r0 < 11 && n < 2000) begin
                @(negedge clk);
                n++;
            end
        end
        check("s4_in_frame", 32'(cs[0]), 32'd0);
        reset = 1'b1;
        #1;
        check("s4_async_cs", 32'(cs[0]), 32'd1);
        check("s4_async_clk", 32'(sclk[0]), 32'd0);
        check("s4_rx_cleared", rxd[0], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("s4_ready", 32'(rdy[0]), 32'd1);
        repeat (20) @(negedge clk);
        check("s4_no_done", 32'(dcnt[0] - d0), 32'd0);
        check("s4_rx_hold", rxd[0], 32'h0);
        send(0, 16'h1234, 16'h5678);
        wait_done(0, "s4_done");
        check("s4_rx", rxd[0], 32'h12345678);

        // request pulsed while busy is ignored
        repeat (10) @(negedge clk);
        snap(0);
        send(0, 16'h5A5A, 16'h0F0F);
        repeat (40) @(negedge clk);
        rv[0] = 1'b1; ra[0] = 16'hDEAD; rd[0] = 16'hBEEF;
        #1;
        check("s5_ready_low", 32'(rdy[0]), 32'd0);
        check("s5_busy", 32'(bsy[0]), 32'd1);
        @(negedge clk);
        rv[0] = 1'b0;
        wait_done(0, "s5_done");
        check("s5_rx", rxd[0], 32'h5A5A0F0F);
        repeat (200) @(negedge clk);
        check("s5_one_frame", 32'(dcnt[0] - d0), 32'd1);
        check("s5_cs_low", 32'(lowc[0] - l0), 32'd130);

        // CLKDIV=1
        snap(1);
        send(1, 16'h0000, 16'hFFFF);
        wait_done(1, "s6_done");
        @(negedge clk);
        check("s6_cs_low", 32'(lowc[1] - l0), 32'd65);
        check("s6_rises", 32'(rises[1] - r0), 32'd32);
        check("s6_mosi_bits", cap[1], 32'h0000FFFF);
        check("s6_done_pulse", 32'(dn[1]), 32'd0);

        check("clk_while_cs", 32'(cviol[0] + cviol[1]), 32'd0);
        check("ready_in_frame", 32'(rviol[0] + rviol[1]), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_debug_master.md
SPI_DEBUG_MASTER -- requirements
Module: spi_debug_master

Interface
REQ-001 The block SHALL have parameter CLKDIV, default 2, setting the number of clk cycles per spi_clk half-period; legal values are 1..255.
REQ-002 The block SHALL have parameter GAP, default 4, setting the minimum number of clk cycles spi_cs stays high between frames; legal values are 1..255.
REQ-003 The block SHALL have port clk, input, width 1: the single system clock; every flop is on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, width 1: a write request is present.
REQ-006 The block SHALL have port req_ready, output, width 1: the block accepts a request this cycle.
REQ-007 The block SHALL have port req_addr, input, width 16: the target address of the debug write.
REQ-008 The block SHALL have port req_data, input, width 16: the write data.
REQ-009 The block SHALL have port done, output, width 1: a one-cycle pulse marking frame completion.
REQ-010 The block SHALL have port rx_data, output, width 32: the word shifted in from spi_miso during the last frame.
REQ-011 The block SHALL have port busy, output, width 1: high whenever the block is not in IDLE.
REQ-012 The block SHALL have port spi_clk, output, width 1: the SPI clock, mode 0, idle low.
REQ-013 The block SHALL have port spi_cs, output, width 1: the active-low chip select.
REQ-014 The block SHALL have port spi_mosi, output, width 1: serial data out, MSB first.
REQ-015 The block SHALL have port spi_miso, input, width 1: serial data in.

Function
REQ-016 The block SHALL be the initiator side of the debug SPI write protocol; each frame is 32 bits, {req_addr, req_data}, sent MSB first.
REQ-017 The states SHALL be IDLE, SETUP, HIGH, LOW, HOLD and GAP.
REQ-018 req_ready SHALL equal (state==IDLE), combinationally, and SHALL not depend on req_valid.
REQ-019 A handshake SHALL occur on a clk edge where req_valid & req_ready; on that edge the block latches tx_shift={req_addr,req_data}, clears the bit counter and enters SETUP.
REQ-020 In SETUP, spi_cs SHALL be 0, spi_clk SHALL be 0 and spi_mosi SHALL equal tx_shift[31], held for CLKDIV cycles, after which the block enters HIGH.
REQ-021 In HIGH, spi_clk SHALL be 1 for CLKDIV cycles; on the last cycle of HIGH, rx_shift <= {rx_shift[30:0], spi_miso}.
REQ-022 After HIGH, the block SHALL enter HOLD if this was bit 31; otherwise it SHALL enter LOW, shift tx_shift left by 1 and increment the bit counter.
REQ-023 In LOW, spi_clk SHALL be 0 and spi_mosi SHALL be the new tx_shift[31], held for CLKDIV cycles, after which the block enters HIGH.
REQ-024 In HOLD, spi_cs SHALL be 0 and spi_clk SHALL be 0 for CLKDIV cycles.
REQ-025 On exit from HOLD, in the same edge: spi_cs <= 1, rx_data <= rx_shift, done <= 1 for exactly one cycle, and the block enters GAP.
REQ-026 In GAP, spi_cs SHALL be 1 for GAP cycles, counted from the cycle done is high; the block then enters IDLE.
REQ-027 spi_cs low time per frame SHALL be exactly 65*CLKDIV clk cycles, made up of SETUP CLKDIV + 32 HIGH phases + 31 LOW phases + HOLD CLKDIV.
REQ-028 spi_clk SHALL produce exactly 32 rising edges per frame, and none while spi_cs=1.
REQ-029 Back-to-back requests: the next handshake SHALL occur no earlier than GAP cycles after done; req_valid held high SHALL be accepted on the first IDLE cycle.
REQ-030 spi_mosi SHALL be 0 in IDLE and GAP.
REQ-031 rx_data SHALL hold its value between frames.
REQ-032 Inputs req_addr and req_data SHALL be ignored outside the handshake cycle.
REQ-033 spi_clk, spi_cs, spi_mosi, done and rx_data SHALL be driven directly from flops, with no combinational paths to the pins.
REQ-034 The half-period counter SHALL be 8 bits and the bit counter 5 bits; the bit counter SHALL not wrap within a frame.

Reset
REQ-035 When reset is asserted, at any time including mid-frame, the block SHALL asynchronously force state=IDLE, spi_cs=1, spi_clk=0, spi_mosi=0, done=0, rx_data=0, and all counters and shift registers to 0.
REQ-036 A frame aborted by reset SHALL produce no done pulse and SHALL not update rx_data.
REQ-037 In the first cycle after reset deasserts, req_ready SHALL be 1.

Verification
REQ-038 Scenario: CLKDIV=2, request addr=16'h8005, data=16'h0041, spi_miso tied 1 -> MOSI bits sampled on spi_clk rising edges read 32'h80050041; spi_cs low for 130 cycles; done for 1 cycle; rx_data=32'hFFFFFFFF.
REQ-039 Scenario: loopback spi_mosi->spi_miso, addr=16'hF000, data=16'h0001 -> rx_data=32'hF0000001 at done.
REQ-040 Scenario: req_valid held high with two queued requests, GAP=4 -> spi_cs high for exactly 4 cycles between frames, with a second done; req_ready is low throughout the first frame.
REQ-041 Scenario: reset asserted during bit 10 of a frame -> spi_cs=1 and spi_clk=0 with no clk edge required; no done; rx_data=0; the next request completes normally.
REQ-042 Scenario: CLKDIV=1, addr=16'h0000, data=16'hFFFF -> 65-cycle cs-low window; spi_clk toggles every cycle; 32 rising edges are counted.
REQ-043 Scenario: req_valid pulsed while busy -> the request is ignored; no extra frame is sent; req_ready stays 0.
